// File: rtl/button_event_arbiter_if.sv
// Event port between the button arbiter (master) and the display controller (slave).
// Carries the valid/ready event handshake plus the sticky drop flag and its clear.
interface button_event_arbiter_if #(
    parameter int unsigned ID_W = 2
) ();
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;
    logic            evt_drop;
    logic            drop_clr;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_drop,
        input  evt_ready,
        input  drop_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_drop,
        output evt_ready,
        output drop_clr
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Debounces synchronized button levels, latches one pending press per button and
// offers them round-robin on a single valid/ready event port.
module button_event_arbiter #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DEB_CYCLES = 20,
    parameter int unsigned DEB_W      = 5,
    parameter int unsigned ID_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       btn_sync,
    button_event_arbiter_if.master evt
);
    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_CYCLES - 1);

    state_e           state_q, state_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] press;
    logic [DEB_W-1:0] deb_cnt_q [N_BTN];
    logic [DEB_W-1:0] deb_cnt_d [N_BTN];
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any, grant;
    logic             drop_set;
    logic             evt_drop_q, evt_drop_d;

    // Debounce: a level is accepted after DEB_CYCLES consecutive differing samples.
    always_comb begin
        for (int unsigned i = 0; i < N_BTN; i++) begin
            stable_d[i]  = stable_q[i];
            deb_cnt_d[i] = '0;
            if (btn_sync[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    stable_d[i] = btn_sync[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable_d & ~stable_q;

    always_comb begin
        int unsigned idx;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_BTN;
            if (!grant_any && pending_q[ID_W'(idx)]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    // Next-state logic for the offer FSM.
    always_comb begin
        state_d  = state_q;
        evt_id_d = evt_id_q;
        rr_ptr_d = rr_ptr_q;
        grant    = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_any) begin
                    grant    = 1'b1;
                    evt_id_d = grant_id;
                    state_d  = StOffer;
                end
            end
            StOffer: begin
                if (evt.evt_ready) begin
                    rr_ptr_d = ID_W'((int'(evt_id_q) + 1) % N_BTN);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A press landing on the same edge as its grant re-arms pending without a drop.
    always_comb begin
        pending_d = pending_q;
        drop_set  = 1'b0;
        if (grant) begin
            pending_d[grant_id] = 1'b0;
        end
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (press[i]) begin
                if (pending_d[i]) begin
                    drop_set = 1'b1;
                end
                pending_d[i] = 1'b1;
            end
        end
        evt_drop_d = drop_set | (evt_drop_q & ~evt.drop_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            stable_q   <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            evt_id_q   <= '0;
            evt_drop_q <= 1'b0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            evt_id_q   <= evt_id_d;
            evt_drop_q <= evt_drop_d;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    always_comb begin
        evt.evt_valid = (state_q == StOffer);
        evt.evt_id    = evt_id_q;
        evt.evt_drop  = evt_drop_q;
    end
endmodule
